// File: rtl/seq_mult16_csa_pkg.sv
// Shared constants and state encodings for the sequential 16x16 carry-skip multiplier.
// Other files pick these up with import seq_mult16_csa_pkg::*.
package seq_mult16_csa_pkg;

  localparam int unsigned WIDTH    = 16;
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned PROD_W   = 2 * WIDTH;
  localparam int unsigned SKIP_BLK = 4;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  // Partial-product operand: the multiplicand when the current multiplier bit is set, else zero.
  function automatic logic [WIDTH-1:0] gate_mcand(input logic [WIDTH-1:0] mcand,
                                                  input logic             bit_set);
    return bit_set ? mcand : '0;
  endfunction

endpackage

// File: rtl/seq_mult16_csa_cskipa16.sv
// 16-bit carry-skip adder built from four 4-bit ripple blocks.
// A block whose bits all propagate passes its incoming carry straight through.
module CSkipA16
  import seq_mult16_csa_pkg::*;
(
  output logic [WIDTH-1:0] S,
  output logic             cout,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y
);

  localparam int unsigned NumBlk = WIDTH / SKIP_BLK;

  logic [WIDTH-1:0] gen;
  logic [WIDTH-1:0] prop;

  assign gen  = x & y;
  assign prop = x ^ y;

  // Carries are walked with procedural variables so the chain is not a combinational loop.
  always_comb begin
    logic blk_cin;
    logic rip_c;
    logic blk_p;
    S       = '0;
    blk_cin = 1'b0;
    for (int blk = 0; blk < NumBlk; blk++) begin
      rip_c = blk_cin;
      blk_p = 1'b1;
      for (int i = 0; i < SKIP_BLK; i++) begin
        S[blk*SKIP_BLK + i] = prop[blk*SKIP_BLK + i] ^ rip_c;
        rip_c = gen[blk*SKIP_BLK + i] | (prop[blk*SKIP_BLK + i] & rip_c);
        blk_p = blk_p & prop[blk*SKIP_BLK + i];
      end
      blk_cin = blk_p ? blk_cin : rip_c;
    end
    cout = blk_cin;
  end

endmodule

// File: rtl/seq_mult16_csa.sv
// Sequential 16x16 unsigned shift-add multiplier, one partial-product add per cycle
// through a single CSkipA16; start/busy/done handshake, product held until the next result.
module seq_mult16_csa
  import seq_mult16_csa_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [WIDTH-1:0]  a,
  input  logic [WIDTH-1:0]  b,
  output logic              busy,
  output logic              done,
  output logic [PROD_W-1:0] product
);

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  mcand_q, mcand_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic [PROD_W-1:0] product_q, product_d;
  logic              done_q, done_d;

  logic [WIDTH-1:0]  add_y;
  logic [WIDTH-1:0]  add_sum;
  logic              add_cout;

  assign add_y = gate_mcand(mcand_q, acc_lo_q[0]);

  CSkipA16 u_add (
    .S    (add_sum),
    .cout (add_cout),
    .x    (acc_hi_q),
    .y    (add_y)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mcand_d   = mcand_q;
    acc_hi_d  = acc_hi_q;
    acc_lo_d  = acc_lo_q;
    product_d = product_q;
    done_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          mcand_d  = a;
          acc_lo_d = b;
          acc_hi_d = '0;
          cnt_d    = '0;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        // 33-bit right shift: the adder carry lands in bit 31 before the next add.
        {acc_hi_d, acc_lo_d} = {add_cout, add_sum, acc_lo_q[WIDTH-1:1]};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        product_d = {acc_hi_q, acc_lo_q};
        done_d    = 1'b1;
        state_d   = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      mcand_q   <= '0;
      acc_hi_q  <= '0;
      acc_lo_q  <= '0;
      product_q <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mcand_q   <= mcand_d;
      acc_hi_q  <= acc_hi_d;
      acc_lo_q  <= acc_lo_d;
      product_q <= product_d;
      done_q    <= done_d;
    end
  end

  assign busy    = (state_q == ST_RUN) || (state_q == ST_DONE);
  assign done    = done_q;
  assign product = product_q;

endmodule
